// File: rtl/sp_eval_pkg.sv
// Shared types and constants for the PPU sprite evaluation slice: the
// secondary OAM slot layout, sprite geometry and the evaluation FSM states.
package sp_eval_pkg;

    localparam int SPRITE_WIDTH = 8;
    localparam int SPRITE_H8    = 8;
    localparam int SPRITE_H16   = 16;
    localparam int OAM_ENTRIES  = 64;
    localparam int SEC_ENTRIES  = 8;

    typedef struct packed {
        logic [7:0]              y_pos;
        logic [7:0]              tile_idx;
        logic [7:0]              attribute;
        logic [7:0]              x_pos;
        logic [SPRITE_WIDTH-1:0] bitmap_lo;
        logic [SPRITE_WIDTH-1:0] bitmap_hi;
        logic                    active;
    } second_oam_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN_Y,
        SCAN_CHK,
        COPY,
        FETCH_LO,
        FETCH_HI,
        DONE
    } sp_eval_state_t;

endpackage

// File: rtl/sp_eval_if.sv
// Memory-side bus of the sprite evaluator: primary OAM read port and the
// VRAM pattern fetch handshake.
interface sp_eval_if;

    logic [7:0]  oam_addr;
    logic [7:0]  oam_rd_data;
    logic        vram_req;
    logic [13:0] vram_addr;
    logic        vram_ack;
    logic [7:0]  vram_rd_data;

    modport master (
        output oam_addr, vram_req, vram_addr,
        input  oam_rd_data, vram_ack, vram_rd_data
    );

    modport slave (
        input  oam_addr, vram_req, vram_addr,
        output oam_rd_data, vram_ack, vram_rd_data
    );

endinterface

// File: rtl/sp_pattern_addr.sv
// Pattern-table byte address for one sprite row and bitplane. Only the low
// nibbles of row and y matter: the offset into a sprite never exceeds 15.
import sp_eval_pkg::*;

module sp_pattern_addr (
    input  logic [3:0]  row,
    input  logic [3:0]  y_pos,
    input  logic [7:0]  tile,
    input  logic        vflip,
    input  logic        size16,
    input  logic        pt_sel,
    input  logic        plane,
    output logic [13:0] addr
);

    logic [3:0] fy_raw;
    logic [3:0] fy;

    always_comb begin
        fy_raw = row - y_pos;
        fy     = vflip ? ((size16 ? 4'(SPRITE_H16 - 1) : 4'(SPRITE_H8 - 1)) - fy_raw) : fy_raw;
        // 8x16 sprites pick their table from tile bit 0 and span two tiles.
        if (size16) addr = {1'b0, tile[0], tile[7:1], fy[3], plane, fy[2:0]};
        else        addr = {1'b0, pt_sel, tile, plane, fy[2:0]};
    end

endmodule

// File: rtl/sp_eval.sv
// Per-scanline sprite evaluation: scans primary OAM into a working secondary
// OAM, fetches pattern bitplanes, and publishes the buffer on line_swap.
import sp_eval_pkg::*;

module sp_eval (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           eval_start,
    input  logic [8:0]                     row,
    input  logic                           sp_size16,
    input  logic                           sp_pt_sel,
    input  logic                           line_swap,
    sp_eval_if.master                      bus,
    output second_oam_t [SEC_ENTRIES-1:0]  sec_oam,
    output logic                           sp_overflow,
    output logic                           sp0_present,
    output logic                           busy,
    output logic                           eval_done
);

    localparam logic [5:0] LAST_ENTRY = 6'(OAM_ENTRIES - 1);

    sp_eval_state_t                 state, state_n;
    logic [5:0]                     n;
    logic [3:0]                     s;
    logic [1:0]                     cidx;
    logic [8:0]                     row_q;
    logic                           size16_q, pt_sel_q;
    second_oam_t [SEC_ENTRIES-1:0]  work;
    logic                           work_ovf, work_sp0;
    logic                           req_q;

    logic [2:0] slot;
    logic [8:0] y_ext, h;
    logic       in_range, last_entry, slot_active, ack_hit;

    assign slot        = s[2:0];
    assign y_ext       = {1'b0, bus.oam_rd_data};
    assign h           = size16_q ? 9'(SPRITE_H16) : 9'(SPRITE_H8);
    assign in_range    = (y_ext <= row_q) && (row_q < y_ext + h);
    assign last_entry  = (n == LAST_ENTRY);
    assign slot_active = work[slot].active;
    assign ack_hit     = req_q && bus.vram_ack;
    assign bus.vram_req = req_q;

    sp_pattern_addr u_pattern_addr (
        .row    (row_q[3:0]),
        .y_pos  (work[slot].y_pos[3:0]),
        .tile   (work[slot].tile_idx),
        .vflip  (work[slot].attribute[7]),
        .size16 (size16_q),
        .pt_sel (pt_sel_q),
        .plane  (state == FETCH_HI),
        .addr   (bus.vram_addr)
    );

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        state_n      = state;
        bus.oam_addr = '0;
        busy         = (state != IDLE);
        eval_done    = (state == DONE);
        case (state)
            CLEAR:  state_n = SCAN_Y;
            SCAN_Y: begin
                bus.oam_addr = {n, 2'b00};
                state_n      = SCAN_CHK;
            end
            SCAN_CHK: begin
                // Tile byte is requested speculatively so an accepted entry copies back-to-back.
                bus.oam_addr = {n, 2'b01};
                if (in_range && !s[3]) state_n = COPY;
                else if (last_entry)   state_n = FETCH_LO;
                else                   state_n = SCAN_Y;
            end
            COPY: begin
                bus.oam_addr = {n, (cidx == 2'd0) ? 2'b10 : 2'b11};
                if (cidx == 2'd2) state_n = last_entry ? FETCH_LO : SCAN_Y;
            end
            FETCH_LO: begin
                if (!slot_active) begin
                    if (slot == 3'd7) state_n = DONE;
                end else if (ack_hit) begin
                    state_n = FETCH_HI;
                end
            end
            FETCH_HI: if (ack_hit) state_n = (slot == 3'd7) ? DONE : FETCH_LO;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
        if (eval_start) state_n = CLEAR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            n           <= '0;
            s           <= '0;
            cidx        <= '0;
            row_q       <= '0;
            size16_q    <= 1'b0;
            pt_sel_q    <= 1'b0;
            // NOTE: both slot arrays are reset so a swap right after reset publishes all-inactive.
            work        <= '0;
            sec_oam     <= '0;
            work_ovf    <= 1'b0;
            work_sp0    <= 1'b0;
            sp_overflow <= 1'b0;
            sp0_present <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            state <= state_n;

            if (line_swap) begin
                if (busy) begin
                    sec_oam     <= '0;
                    sp0_present <= 1'b0;
                end else begin
                    sec_oam     <= work;
                    sp_overflow <= work_ovf;
                    sp0_present <= work_sp0;
                end
            end

            if (eval_start) begin
                row_q    <= row;
                size16_q <= sp_size16;
                pt_sel_q <= sp_pt_sel;
                work_ovf <= 1'b0;
                work_sp0 <= 1'b0;
                req_q    <= 1'b0;
            end else begin
                case (state)
                    CLEAR: begin
                        work <= '0;
                        n    <= '0;
                        s    <= '0;
                    end
                    SCAN_CHK: begin
                        if (in_range && !s[3]) begin
                            work[slot].y_pos  <= bus.oam_rd_data;
                            work[slot].active <= 1'b1;
                            cidx              <= '0;
                            if (n == 6'd0) work_sp0 <= 1'b1;
                        end else begin
                            if (in_range) work_ovf <= 1'b1;
                            n <= n + 6'd1;
                            if (last_entry) s <= '0;
                        end
                    end
                    COPY: begin
                        case (cidx)
                            2'd0:    work[slot].tile_idx  <= bus.oam_rd_data;
                            2'd1:    work[slot].attribute <= bus.oam_rd_data;
                            default: work[slot].x_pos     <= bus.oam_rd_data;
                        endcase
                        cidx <= cidx + 2'd1;
                        if (cidx == 2'd2) begin
                            n <= n + 6'd1;
                            s <= last_entry ? 4'd0 : s + 4'd1;
                        end
                    end
                    FETCH_LO, FETCH_HI: begin
                        if (!slot_active) begin
                            s <= s + 4'd1;
                        end else if (!req_q) begin
                            req_q <= 1'b1;
                        end else if (bus.vram_ack) begin
                            req_q <= 1'b0;
                            if (state == FETCH_LO) begin
                                work[slot].bitmap_lo <= bus.vram_rd_data;
                            end else begin
                                work[slot].bitmap_hi <= bus.vram_rd_data;
                                s <= s + 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sp_eval.sv
// Self-checking bench for sp_eval: directed address vectors, the multi-cycle
// abort/swap/reset sequences, and randomized OAM contents against a reference model.
import sp_eval_pkg::*;

module tb_sp_eval;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        eval_start = 1'b0;
    logic [8:0]  row = '0;
    logic        sp_size16 = 1'b0;
    logic        sp_pt_sel = 1'b0;
    logic        line_swap = 1'b0;
    second_oam_t [SEC_ENTRIES-1:0] sec_oam;
    logic        sp_overflow, sp0_present, busy, eval_done;

    sp_eval_if bus();

    sp_eval dut (
        .clk         (clk),
        .rst         (rst),
        .eval_start  (eval_start),
        .row         (row),
        .sp_size16   (sp_size16),
        .sp_pt_sel   (sp_pt_sel),
        .line_swap   (line_swap),
        .bus         (bus),
        .sec_oam     (sec_oam),
        .sp_overflow (sp_overflow),
        .sp0_present (sp0_present),
        .busy        (busy),
        .eval_done   (eval_done)
    );

    always #5 clk = ~clk;

    // ---------------- memory models ----------------
    logic [7:0]  oam_mem [256];
    int          ack_lat = 0;
    int          wait_cnt = 0;
    int unsigned addr_log[$];

    function automatic logic [7:0] pat(input logic [13:0] a);
        return a[7:0] ^ {a[13:8], 2'b01};
    endfunction

    always @(posedge clk) bus.oam_rd_data <= oam_mem[bus.oam_addr];

    always @(posedge clk) begin
        if (rst || !bus.vram_req || bus.vram_ack) begin
            bus.vram_ack <= 1'b0;
            wait_cnt     <= 0;
        end else if (wait_cnt >= ack_lat) begin
            bus.vram_ack     <= 1'b1;
            bus.vram_rd_data <= pat(bus.vram_addr);
            addr_log.push_back(32'(bus.vram_addr));
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // ---------------- reference model ----------------
    second_oam_t [7:0] exp_buf;
    bit                exp_ovf, exp_sp0;
    int unsigned       exp_addrs[$];

    second_oam_t [7:0] pub_buf = '0;
    bit                pub_ovf = 1'b0, pub_sp0 = 1'b0;

    function automatic void model(input int r, input bit s16, input bit pt);
        int h, cnt, y, fy, tile, a;
        h = s16 ? 16 : 8;
        cnt = 0;
        exp_buf = '0;
        exp_ovf = 1'b0;
        exp_sp0 = 1'b0;
        exp_addrs.delete();
        for (int i = 0; i < 64; i++) begin
            y = int'(oam_mem[4*i]);
            if (y <= r && r < y + h) begin
                if (cnt == 8) begin
                    exp_ovf = 1'b1;
                end else begin
                    exp_buf[cnt].y_pos     = 8'(y);
                    exp_buf[cnt].tile_idx  = oam_mem[4*i+1];
                    exp_buf[cnt].attribute = oam_mem[4*i+2];
                    exp_buf[cnt].x_pos     = oam_mem[4*i+3];
                    exp_buf[cnt].active    = 1'b1;
                    if (i == 0) exp_sp0 = 1'b1;
                    cnt++;
                end
            end
        end
        for (int k = 0; k < cnt; k++) begin
            fy = r - int'(exp_buf[k].y_pos);
            if (exp_buf[k].attribute[7]) fy = h - 1 - fy;
            tile = int'(exp_buf[k].tile_idx);
            for (int plane = 0; plane < 2; plane++) begin
                if (s16) a = (tile % 2) * 4096 + (tile / 2) * 32 + (fy / 8) * 16 + plane * 8 + fy % 8;
                else     a = (pt ? 4096 : 0) + tile * 16 + plane * 8 + fy;
                exp_addrs.push_back(a);
                if (plane == 0) exp_buf[k].bitmap_lo = pat(14'(a));
                else            exp_buf[k].bitmap_hi = pat(14'(a));
            end
        end
    endfunction

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_pub(input string tag);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s slot%0d", tag, i), 64'(sec_oam[i]), 64'(pub_buf[i]));
        check({tag, " overflow"}, 64'(sp_overflow), 64'(pub_ovf));
        check({tag, " sp0"}, 64'(sp0_present), 64'(pub_sp0));
    endtask

    task automatic check_addrs(input string tag);
        check({tag, " fetch count"}, 64'(addr_log.size()), 64'(exp_addrs.size()));
        for (int i = 0; i < exp_addrs.size(); i++)
            check($sformatf("%s addr%0d", tag, i),
                  (i < addr_log.size()) ? 64'(addr_log[i]) : 64'hFFFF_FFFF, 64'(exp_addrs[i]));
    endtask

    task automatic start_eval(input int r, input bit s16, input bit pt);
        addr_log.delete();
        @(posedge clk); #1;
        row        = 9'(r);
        sp_size16  = s16;
        sp_pt_sel  = pt;
        eval_start = 1'b1;
        @(posedge clk); #1;
        eval_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit got = 1'b0;
        bit busy_ok = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (eval_done) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, " eval_done seen"}, 64'(got), 64'd1);
        check({tag, " busy held"}, 64'(busy_ok), 64'd1);
        @(negedge clk);
        check({tag, " idle after done"}, 64'({busy, eval_done}), 64'd0);
    endtask

    task automatic swap(input bit exp_busy);
        @(posedge clk); #1;
        line_swap = 1'b1;
        @(posedge clk); #1;
        line_swap = 1'b0;
        if (exp_busy) begin
            pub_buf = '0;
            pub_sp0 = 1'b0;
        end else begin
            pub_buf = exp_buf;
            pub_ovf = exp_ovf;
            pub_sp0 = exp_sp0;
        end
    endtask

    task automatic finish_and_check(input string tag);
        wait_done(tag);
        swap(1'b0);
        @(negedge clk);
        check_pub(tag);
        check_addrs(tag);
    endtask

    task automatic run(input string tag, input int r, input bit s16, input bit pt);
        model(r, s16, pt);
        start_eval(r, s16, pt);
        finish_and_check(tag);
    endtask

    task automatic fill_filler();
        for (int i = 0; i < 64; i++) begin
            oam_mem[4*i]   = 8'hF0;
            oam_mem[4*i+1] = 8'(i * 7);
            oam_mem[4*i+2] = 8'(i * 5);
            oam_mem[4*i+3] = 8'(i);
        end
    endtask

    // ---------------- directed pattern-address vectors ----------------
    typedef struct {
        int y;
        int tile;
        int attr;
        int r;
        bit s16;
        bit pt;
        bit hit;
        int lo;
        int hi;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{y: 15,  tile: 'h42, attr: 'h80, r: 15,  s16: 0, pt: 1, hit: 1, lo: 'h1427, hi: 'h142F};
        vecs[1] = '{y: 100, tile: 'h17, attr: 'h00, r: 110, s16: 1, pt: 0, hit: 1, lo: 'h1172, hi: 'h117A};
        vecs[2] = '{y: 10,  tile: 'h05, attr: 'h00, r: 12,  s16: 0, pt: 0, hit: 1, lo: 'h0052, hi: 'h005A};
        vecs[3] = '{y: 0,   tile: 'h20, attr: 'h80, r: 3,   s16: 1, pt: 0, hit: 1, lo: 'h0214, hi: 'h021C};
        vecs[4] = '{y: 250, tile: 'hFF, attr: 'h00, r: 257, s16: 0, pt: 1, hit: 1, lo: 'h1FF7, hi: 'h1FFF};
        vecs[5] = '{y: 10,  tile: 'h01, attr: 'h00, r: 9,   s16: 0, pt: 0, hit: 0, lo: 0,       hi: 0};
        vecs[6] = '{y: 10,  tile: 'h01, attr: 'h00, r: 18,  s16: 0, pt: 0, hit: 0, lo: 0,       hi: 0};
        vecs[7] = '{y: 10,  tile: 'h01, attr: 'h00, r: 25,  s16: 1, pt: 0, hit: 1, lo: 'h1017, hi: 'h101F};

        fill_filler();

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_pub("reset");
        check("reset busy", 64'(busy), 64'd0);
        check("reset eval_done", 64'(eval_done), 64'd0);
        check("reset vram_req", 64'(bus.vram_req), 64'd0);
        check("reset oam_addr", 64'(bus.oam_addr), 64'd0);

        // Single-sprite address vectors at entry 0
        for (int v = 0; v < 8; v++) begin
            fill_filler();
            oam_mem[0] = 8'(vecs[v].y);
            oam_mem[1] = 8'(vecs[v].tile);
            oam_mem[2] = 8'(vecs[v].attr);
            oam_mem[3] = 8'h33;
            run($sformatf("vec%0d", v), vecs[v].r, vecs[v].s16, vecs[v].pt);
            check($sformatf("vec%0d hit", v), 64'(sec_oam[0].active), 64'(vecs[v].hit));
            check($sformatf("vec%0d sp0", v), 64'(sp0_present), 64'(vecs[v].hit));
            if (vecs[v].hit) begin
                check($sformatf("vec%0d lo addr", v),
                      (addr_log.size() > 0) ? 64'(addr_log[0]) : 64'hDEAD, 64'(vecs[v].lo));
                check($sformatf("vec%0d hi addr", v),
                      (addr_log.size() > 1) ? 64'(addr_log[1]) : 64'hDEAD, 64'(vecs[v].hi));
            end
        end

        // Entries 3 and 40, row 15, 8x8
        fill_filler();
        oam_mem[4*3]  = 8'd10;
        oam_mem[4*40] = 8'd20;
        run("two sprites", 15, 1'b0, 1'b0);
        check("two sprites slot0 y", 64'(sec_oam[0].y_pos), 64'd10);
        check("two sprites slot0 x", 64'(sec_oam[0].x_pos), 64'd3);
        check("two sprites slot1 active", 64'(sec_oam[1].active), 64'd0);

        // Ten sprites on the same line: overflow, first eight kept
        fill_filler();
        for (int i = 0; i < 10; i++) oam_mem[4*i] = 8'd5;
        ack_lat = 2;
        run("ten sprites", 7, 1'b0, 1'b1);
        check("ten sprites overflow", 64'(sp_overflow), 64'd1);
        check("ten sprites slot7 x", 64'(sec_oam[7].x_pos), 64'd7);
        ack_lat = 0;

        // Abort mid-scan, swap while busy, then the new row completes
        fill_filler();
        for (int i = 0; i < 64; i++) oam_mem[4*i] = (i < 32) ? 8'd25 : 8'd95;
        start_eval(30, 1'b0, 1'b0);
        repeat (50) @(posedge clk);
        start_eval(100, 1'b0, 1'b0);
        model(100, 1'b0, 1'b0);
        swap(1'b1);
        @(negedge clk);
        check_pub("abort busy swap");
        finish_and_check("abort new row");

        // Simultaneous eval_start and line_swap while idle
        model(25, 1'b0, 1'b0);
        start_eval(25, 1'b0, 1'b0);
        wait_done("pre simul");
        pub_buf = exp_buf;
        pub_ovf = exp_ovf;
        pub_sp0 = exp_sp0;
        @(posedge clk); #1;
        row = 9'd97;
        eval_start = 1'b1;
        line_swap  = 1'b1;
        addr_log.delete();
        @(posedge clk); #1;
        eval_start = 1'b0;
        line_swap  = 1'b0;
        @(negedge clk);
        check_pub("simul swap");
        check("simul busy", 64'(busy), 64'd1);
        model(97, 1'b0, 1'b0);
        finish_and_check("simul new row");

        // Reset in the middle of a pattern fetch
        fill_filler();
        oam_mem[4*5] = 8'd40;
        ack_lat = 6;
        start_eval(42, 1'b0, 1'b0);
        begin
            bit seen = 1'b0;
            for (int cyc = 0; cyc < 500; cyc++) begin
                @(negedge clk);
                if (bus.vram_req) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("midfetch req seen", 64'(seen), 64'd1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        pub_buf = '0;
        pub_ovf = 1'b0;
        pub_sp0 = 1'b0;
        check("midfetch rst vram_req", 64'(bus.vram_req), 64'd0);
        check("midfetch rst busy", 64'(busy), 64'd0);
        check("midfetch rst eval_done", 64'(eval_done), 64'd0);
        check("midfetch rst oam_addr", 64'(bus.oam_addr), 64'd0);
        check_pub("midfetch rst");
        exp_buf = '0;
        exp_ovf = 1'b0;
        exp_sp0 = 1'b0;
        swap(1'b0);
        @(negedge clk);
        check_pub("post rst swap");
        ack_lat = 0;

        // Randomized OAM contents against the model
        for (int t = 0; t < 16; t++) begin
            int r, y;
            bit s16, pt;
            r   = int'($urandom_range(0, 261));
            s16 = 1'($urandom_range(0, 1));
            pt  = 1'($urandom_range(0, 1));
            ack_lat = int'($urandom_range(0, 3));
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    y = r - int'($urandom_range(0, 17));
                    if (y < 0) y = 0;
                    if (y > 255) y = 255;
                end else begin
                    y = int'($urandom_range(0, 255));
                end
                oam_mem[4*i]   = 8'(y);
                oam_mem[4*i+1] = 8'($urandom);
                oam_mem[4*i+2] = 8'($urandom);
                oam_mem[4*i+3] = 8'($urandom);
            end
            run($sformatf("rand%0d", t), r, s16, pt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
